// File: rtl/bist_engine.sv
// Loadable-vector BIST engine driving an FSM under test, with error capture.
// Optional response MISR enabled by defining BIST_SIGNATURE_EN.
module bist_engine #(
  parameter int IN_W    = 4,
  parameter int OUT_W   = 4,
  parameter int STATE_W = 4,
  parameter int ADDR_W  = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               ABORT,
  input  logic               STOP_ON_ERR,
  input  logic [ADDR_W:0]    TEST_LEN,
  input  logic [STATE_W-1:0] INIT_STATE,
  input  logic               VEC_WE,
  input  logic [ADDR_W-1:0]  VEC_ADDR,
  input  logic [IN_W+OUT_W-1:0] VEC_WDATA,
  input  logic [OUT_W-1:0]   FSM_IN,
  output logic [IN_W-1:0]    FSM_OUT,
  output logic [STATE_W-1:0] FSM_PRESET,
  output logic               FSM_LOAD,
  output logic               FSM_ENABLE,
  output logic               BUSY,
  output logic               DONE,
  output logic [3:0]         STATUS_CODE,
  output logic [ADDR_W:0]    ERR_COUNT,
  output logic [ADDR_W-1:0]  FIRST_ERR_IDX,
  output logic [IN_W-1:0]    FIRST_ERR_IN,
  output logic [OUT_W-1:0]   FIRST_ERR_EXP,
  output logic [OUT_W-1:0]   FIRST_ERR_GOT,
  output logic [15:0]        SIGNATURE
);

  localparam int VW    = IN_W + OUT_W;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] ST_NONE = 4'h0;
  localparam logic [3:0] ST_PASS = 4'hF;
  localparam logic [3:0] ST_FAIL = 4'h5;
  localparam logic [3:0] ST_ABRT = 4'hA;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PRESET, RUN, DRAIN} state_t;

  logic [VW-1:0] mem [DEPTH];

  state_t state_q, state_d;
  logic [ADDR_W:0]    idx_q, idx_d, n_q, n_d, err_q, err_d;
  logic [ADDR_W:0]    n_in, idx_nx, idx_pv;
  logic [IN_W-1:0]    out_q, out_d;
  logic [OUT_W-1:0]   exp_q, exp_d;
  logic [STATE_W-1:0] pre_q, pre_d;
  logic               load_q, load_d;
  logic               en_q, en_d;
  logic               done_q, done_d;
  logic [3:0]         st_q, st_d;
  logic [ADDR_W-1:0]  fidx_q, fidx_d;
  logic [IN_W-1:0]    fin_q, fin_d;
  logic [OUT_W-1:0]   fexp_q, fexp_d;
  logic [OUT_W-1:0]   fgot_q, fgot_d;

  logic [VW-1:0]    rd;
  logic [IN_W-1:0]  rd_stim;
  logic [OUT_W-1:0] rd_exp;
  logic             cmp, miss;

  assign n_in    = (TEST_LEN > LEN_MAX) ? LEN_MAX : TEST_LEN;
  assign idx_nx  = idx_q + 1'b1;
  assign idx_pv  = idx_q - 1'b1;
  assign rd      = mem[idx_q[ADDR_W-1:0]];
  assign rd_stim = rd[IN_W-1:0];
  assign rd_exp  = rd[VW-1:IN_W];

  // exp_q always holds the expectation for the vector the DUT is answering
  assign cmp  = (state_q == RUN) || (state_q == DRAIN);
  assign miss = cmp && (FSM_IN != exp_q);

  always_ff @(negedge CLK) begin
    if (VEC_WE && (state_q == IDLE)) begin
      mem[VEC_ADDR] <= VEC_WDATA;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    err_d   = err_q;
    out_d   = out_q;
    exp_d   = exp_q;
    pre_d   = pre_q;
    load_d  = load_q;
    en_d    = en_q;
    done_d  = done_q;
    st_d    = st_q;
    fidx_d  = fidx_q;
    fin_d   = fin_q;
    fexp_d  = fexp_q;
    fgot_d  = fgot_q;

    if (miss) begin
      err_d = err_q + 1'b1;
      if (err_q == '0) begin
        fidx_d = idx_pv[ADDR_W-1:0];
        fin_d  = out_q;
        fexp_d = exp_q;
        fgot_d = FSM_IN;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (START) begin
          err_d  = '0;
          fidx_d = '0;
          fin_d  = '0;
          fexp_d = '0;
          fgot_d = '0;
          if (n_in == '0) begin
            done_d = 1'b1;
            st_d   = ST_PASS;
          end else begin
            state_d = PRESET;
            load_d  = 1'b1;
            pre_d   = INIT_STATE;
            done_d  = 1'b0;
            st_d    = ST_NONE;
            idx_d   = '0;
            n_d     = n_in;
          end
        end
      end
      PRESET: begin
        load_d  = 1'b0;
        en_d    = 1'b1;
        out_d   = rd_stim;
        exp_d   = rd_exp;
        idx_d   = idx_nx;
        state_d = (n_q == LEN_ONE) ? DRAIN : RUN;
      end
      RUN: begin
        if (miss && STOP_ON_ERR) begin
          state_d = IDLE;
          en_d    = 1'b0;
          done_d  = 1'b1;
          st_d    = ST_FAIL;
        end else begin
          out_d = rd_stim;
          exp_d = rd_exp;
          idx_d = idx_nx;
          if (idx_nx == n_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        en_d    = 1'b0;
        done_d  = 1'b1;
        st_d    = (err_d == '0) ? ST_PASS : ST_FAIL;
      end
      default: state_d = IDLE;
    endcase

    // abort wins over everything except the error capture above
    if (ABORT && (state_q != IDLE)) begin
      state_d = IDLE;
      idx_d   = idx_q;
      out_d   = out_q;
      exp_d   = exp_q;
      en_d    = 1'b0;
      load_d  = 1'b0;
      done_d  = 1'b1;
      st_d    = ST_ABRT;
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      err_q   <= '0;
      out_q   <= '0;
      exp_q   <= '0;
      pre_q   <= '0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      st_q    <= ST_NONE;
      fidx_q  <= '0;
      fin_q   <= '0;
      fexp_q  <= '0;
      fgot_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      err_q   <= err_d;
      out_q   <= out_d;
      exp_q   <= exp_d;
      pre_q   <= pre_d;
      load_q  <= load_d;
      en_q    <= en_d;
      done_q  <= done_d;
      st_q    <= st_d;
      fidx_q  <= fidx_d;
      fin_q   <= fin_d;
      fexp_q  <= fexp_d;
      fgot_q  <= fgot_d;
    end
  end

`ifdef BIST_SIGNATURE_EN
  logic [15:0] sig_q, sig_d;
  logic        go;

  assign go = (state_q == IDLE) && START && (n_in != '0);

  always_comb begin
    sig_d = sig_q;
    if (go) begin
      sig_d = 16'hFFFF;
    end else if (cmp) begin
      sig_d = {sig_q[14:0], 1'b0}
            ^ (sig_q[15] ? 16'h1021 : 16'h0000)
            ^ 16'(FSM_IN);
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) sig_q <= 16'hFFFF;
    else     sig_q <= sig_d;
  end

  assign SIGNATURE = sig_q;
`else
  assign SIGNATURE = 16'h0000;
`endif

  assign FSM_OUT       = out_q;
  assign FSM_PRESET    = pre_q;
  assign FSM_LOAD      = load_q;
  assign FSM_ENABLE    = en_q;
  assign BUSY          = (state_q != IDLE);
  assign DONE          = done_q;
  assign STATUS_CODE   = st_q;
  assign ERR_COUNT     = err_q;
  assign FIRST_ERR_IDX = fidx_q;
  assign FIRST_ERR_IN  = fin_q;
  assign FIRST_ERR_EXP = fexp_q;
  assign FIRST_ERR_GOT = fgot_q;

endmodule

// File: tb/tb_bist_engine.sv
// Scoreboard bench for bist_engine: per-run results queued at START,
// popped when DONE rises; stimuli queued and popped as they are applied.
module tb_bist_engine;

  logic       CLK = 1'b0;
  logic       RST, START, ABORT, STOP_ON_ERR;
  logic [6:0] TEST_LEN;
  logic [3:0] INIT_STATE;
  logic       VEC_WE;
  logic [5:0] VEC_ADDR;
  logic [7:0] VEC_WDATA;
  logic [3:0] FSM_IN;
  logic [3:0] FSM_OUT, FSM_PRESET;
  logic       FSM_LOAD, FSM_ENABLE, BUSY, DONE;
  logic [3:0] STATUS_CODE;
  logic [6:0] ERR_COUNT;
  logic [5:0] FIRST_ERR_IDX;
  logic [3:0] FIRST_ERR_IN, FIRST_ERR_EXP, FIRST_ERR_GOT;
  logic [15:0] SIGNATURE;

  bist_engine dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .STOP_ON_ERR(STOP_ON_ERR), .TEST_LEN(TEST_LEN),
    .INIT_STATE(INIT_STATE), .VEC_WE(VEC_WE), .VEC_ADDR(VEC_ADDR),
    .VEC_WDATA(VEC_WDATA), .FSM_IN(FSM_IN), .FSM_OUT(FSM_OUT),
    .FSM_PRESET(FSM_PRESET), .FSM_LOAD(FSM_LOAD),
    .FSM_ENABLE(FSM_ENABLE), .BUSY(BUSY), .DONE(DONE),
    .STATUS_CODE(STATUS_CODE), .ERR_COUNT(ERR_COUNT),
    .FIRST_ERR_IDX(FIRST_ERR_IDX), .FIRST_ERR_IN(FIRST_ERR_IN),
    .FIRST_ERR_EXP(FIRST_ERR_EXP), .FIRST_ERR_GOT(FIRST_ERR_GOT),
    .SIGNATURE(SIGNATURE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          done_edge;
    logic [3:0]  status;
    logic [6:0]  errs;
    logic [5:0]  fidx;
    logic [3:0]  fin;
    logic [3:0]  fexp;
    logic [3:0]  fgot;
    logic [15:0] sig;
  } res_t;

  res_t       res_q[$];
  logic [3:0] stim_q[$];
  logic [7:0] mem_m [64];
  logic [15:0] sig_m;
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] misr(logic [15:0] s, logic [3:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {12'h000, d};
  endfunction

  task automatic wr(int a, logic [7:0] d);
    @(posedge CLK);
    VEC_WE = 1'b1;
    VEC_ADDR = a[5:0];
    VEC_WDATA = d;
    @(posedge CLK);
    VEC_WE = 1'b0;
    mem_m[a] = d;
  endtask

  // vector k goes out at edge k+1 and is judged at edge k+2
  task automatic predict(int n, bit stop, int fault, int ab, output int applied);
    res_t r;
    bit ended;
    logic [3:0] st, ex, got;
    ended = 1'b0;
    r.done_edge = n + 1;
    r.status = 4'hF;
    r.errs = '0;
    r.fidx = '0;
    r.fin = '0;
    r.fexp = '0;
    r.fgot = '0;
    if (n == 0) r.done_edge = 0;
    else sig_m = 16'hFFFF;
    for (int k = 0; k < n && !ended; k++) begin
      if (ab > 0 && ab < k + 2) begin
        r.done_edge = ab;
        r.status = 4'hA;
        ended = 1'b1;
      end else begin
        st = mem_m[k][3:0];
        ex = mem_m[k][7:4];
        got = (k == fault) ? 4'h7 : st + 4'h1;
        sig_m = misr(sig_m, got);
        if (got != ex) begin
          if (r.errs == 0) begin
            r.fidx = k[5:0];
            r.fin = st;
            r.fexp = ex;
            r.fgot = got;
          end
          r.errs++;
        end
        if (ab == k + 2) begin
          r.done_edge = ab;
          r.status = 4'hA;
          ended = 1'b1;
        end else if (got != ex && stop) begin
          r.done_edge = k + 2;
          r.status = 4'h5;
          ended = 1'b1;
        end
      end
    end
    if (!ended && r.errs != 0) r.status = 4'h5;
`ifdef BIST_SIGNATURE_EN
    r.sig = sig_m;
`else
    r.sig = 16'h0000;
`endif
    applied = (n < r.done_edge - 1) ? n : r.done_edge - 1;
    if (applied < 0) applied = 0;
    for (int k = 0; k < applied; k++) stim_q.push_back(mem_m[k][3:0]);
    res_q.push_back(r);
  endtask

  task automatic run(int n_raw, bit stop, int fault, int ab, int we_at);
    int n, applied, c;
    res_t r;
    logic [3:0] init;
    n = (n_raw > 64) ? 64 : n_raw;
    init = 4'($urandom_range(1, 15));
    stim_q.delete();
    predict(n, stop, fault, ab, applied);
    @(posedge CLK);
    START = 1'b1;
    ABORT = (ab == 0);
    TEST_LEN = n_raw[6:0];
    STOP_ON_ERR = stop;
    INIT_STATE = init;
    @(posedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    c = 0;
    chk("load_e0", FSM_LOAD, n != 0);
    if (n != 0) begin
      chk("preset_e0", FSM_PRESET, init);
      chk("status_run", STATUS_CODE, 0);
    end
    while (c <= 200 && DONE !== 1'b1) begin
      chk("busy", BUSY, 1);
      if (c >= 1) begin
        chk("enable", FSM_ENABLE, 1);
        chk("load_low", FSM_LOAD, 0);
        if (c - 1 < applied && stim_q.size() > 0)
          chk("stim", FSM_OUT, stim_q.pop_front());
      end
      FSM_IN = (c - 1 == fault) ? 4'h7 : FSM_OUT + 4'h1;
      ABORT = (c + 1 == ab);
      VEC_WE = (c == we_at);
      VEC_ADDR = 6'd5;
      VEC_WDATA = ~mem_m[5];
      @(posedge CLK);
      c++;
    end
    ABORT = 1'b0;
    VEC_WE = 1'b0;
    r = res_q.pop_front();
    chk("done_edge", c, r.done_edge);
    chk("status", STATUS_CODE, r.status);
    chk("err_count", ERR_COUNT, r.errs);
    chk("first_idx", FIRST_ERR_IDX, r.fidx);
    chk("first_in", FIRST_ERR_IN, r.fin);
    chk("first_exp", FIRST_ERR_EXP, r.fexp);
    chk("first_got", FIRST_ERR_GOT, r.fgot);
    chk("signature", SIGNATURE, r.sig);
    chk("idle_ctl", {BUSY, FSM_ENABLE, FSM_LOAD}, 0);
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_ctl"}, {FSM_OUT, FSM_PRESET, FSM_LOAD, FSM_ENABLE, BUSY, DONE}, 0);
    chk({tag, "_stat"}, {STATUS_CODE, ERR_COUNT}, 0);
    chk({tag, "_first"}, {FIRST_ERR_IDX, FIRST_ERR_IN, FIRST_ERR_EXP, FIRST_ERR_GOT}, 0);
`ifdef BIST_SIGNATURE_EN
    chk({tag, "_sig"}, SIGNATURE, 16'hFFFF);
`else
    chk({tag, "_sig"}, SIGNATURE, 16'h0000);
`endif
  endtask

  task automatic rst_mid();
    @(posedge CLK);
    START = 1'b1;
    TEST_LEN = 7'd4;
    STOP_ON_ERR = 1'b0;
    @(posedge CLK);
    START = 1'b0;
    repeat (2) @(posedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    chk_reset("rst_mid");
    RST = 1'b0;
    sig_m = 16'hFFFF;
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    ABORT = 1'b0;
    STOP_ON_ERR = 1'b0;
    TEST_LEN = '0;
    INIT_STATE = '0;
    VEC_WE = 1'b0;
    VEC_ADDR = '0;
    VEC_WDATA = '0;
    FSM_IN = '0;
    sig_m = 16'hFFFF;
    repeat (2) @(posedge CLK);
    chk_reset("reset");
    RST = 1'b0;

    for (int i = 0; i < 64; i++) wr(i, 8'($urandom));
    wr(0, 8'h21);
    wr(1, 8'h32);
    wr(2, 8'h43);
    wr(3, 8'h54);

    run(4, 1'b0, -1, -1, -1);
    run(0, 1'b0, -1, -1, -1);
    run(4, 1'b0, 2, -1, -1);
    run(4, 1'b1, 2, -1, -1);
    run(64, 1'b0, -1, 11, 3);
    run(100, 1'b0, -1, -1, -1);
    run(1, 1'b0, -1, -1, -1);
    run(4, 1'b0, -1, 0, -1);
    rst_mid();
    run(4, 1'b0, -1, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
